// File: rtl/pc_pkg.sv
// Shared types, default widths and parameter checks for the program-counter unit.
package pc_pkg;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_INSTR_BYTES = 4;
  localparam int unsigned DEF_RAS_DEPTH   = 4;

  // Next-PC source select, listed in no particular priority order
  typedef enum logic [2:0] {
    NPC_SEQ,
    NPC_JMP,
    NPC_RET,
    NPC_REDIR,
    NPC_HOLD
  } npc_sel_e;

  // RAS depth must be a power of two (pointer wraps naturally) and at least 2
  function automatic bit ras_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// Circular return-address stack: push/pop, pop-then-push, saturating count, sticky overflow.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_RAS_DEPTH,
  parameter int unsigned W     = DEF_ADDR_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         full_o,
  output logic         ovf_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  // ptr_q is the next free slot; the top entry sits one below it
  assign top_idx = ptr_q - PTR_W'(1);
  assign top_o   = mem_q[top_idx];
  assign empty_o = empty_q;
  assign full_o  = full_q;
  assign ovf_o   = ovf_q;

  // Next stack state from the requested operation
  always_comb begin
    mem_d = mem_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push_i && pop_i && !empty_q) begin
      // pop then push collapses to replacing the top entry
      mem_d[top_idx] = push_data_i;
    end else if (push_i) begin
      // when full, the slot at ptr_q is the oldest entry and gets overwritten
      mem_d[ptr_q] = push_data_i;
      ptr_d        = ptr_q + PTR_W'(1);
      if (full_q) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_i && !empty_q) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_W'(DEPTH));
  end

  // Stack registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ptr_q   <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter at the head of IF: next-PC priority mux, PC register, incrementer and RAS.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned        ADDR_W      = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0]  RESET_VEC   = '0,
  parameter int unsigned        INSTR_BYTES = DEF_INSTR_BYTES,
  parameter int unsigned        RAS_DEPTH   = DEF_RAS_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_write,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              jump_i,
  input  logic              call_i,
  input  logic [ADDR_W-1:0] jump_pc_i,
  input  logic [ADDR_W-1:0] link_pc_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] ret_pc_i,
  output logic [ADDR_W-1:0] pc_out_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_ovf_o
);

  if (!ras_depth_ok(RAS_DEPTH)) begin : g_depth_check
    $error("pc_unit: RAS_DEPTH must be a power of two and at least 2");
  end

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ras_top;
  logic              advance;
  logic              ras_push;
  logic              ras_pop;
  npc_sel_e          npc_sel;

  assign pc_out_o  = pc_q;
  assign pc_plus_o = pc_q + ADDR_W'(INSTR_BYTES);

  // RAS only moves when the ID-stage control flow actually takes effect
  assign advance  = pc_write && !redirect_i;
  assign ras_push = advance && call_i;
  assign ras_pop  = advance && ret_i;

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (link_pc_i),
    .top_o       (ras_top),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o),
    .ovf_o       (ras_ovf_o)
  );

  // Priority select: flush beats stall, return beats jump/call, else sequential
  always_comb begin
    npc_sel = NPC_SEQ;
    if (redirect_i) begin
      npc_sel = NPC_REDIR;
    end else if (!pc_write) begin
      npc_sel = NPC_HOLD;
    end else if (ret_i) begin
      npc_sel = NPC_RET;
    end else if (jump_i || call_i) begin
      npc_sel = NPC_JMP;
    end
  end

  // Next-PC mux; an empty RAS falls back to the register-file return address
  always_comb begin
    pc_d = pc_q;
    case (npc_sel)
      NPC_REDIR: pc_d = redirect_pc_i;
      NPC_HOLD:  pc_d = pc_q;
      NPC_RET:   pc_d = ras_empty_o ? ret_pc_i : ras_top;
      NPC_JMP:   pc_d = jump_pc_i;
      default:   pc_d = pc_plus_o;
    endcase
  end

  // PC register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed vector table, corner sequences, random vs queue model.
module tb_pc_unit;

  localparam int unsigned RAS_DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i, pc_write, redirect_i, jump_i, call_i, ret_i;
  logic [31:0] redirect_pc_i, jump_pc_i, link_pc_i, ret_pc_i;
  logic [31:0] pc_out_o, pc_plus_o;
  logic        ras_empty_o, ras_full_o, ras_ovf_o;
  logic [7:0]  pc8_out, pc8_plus;
  logic        e8, f8, o8;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk_i = ~clk_i;

  pc_unit #(.ADDR_W(32), .RESET_VEC(32'h0), .INSTR_BYTES(4), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pc_write(pc_write),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .jump_i(jump_i), .call_i(call_i), .jump_pc_i(jump_pc_i), .link_pc_i(link_pc_i),
    .ret_i(ret_i), .ret_pc_i(ret_pc_i),
    .pc_out_o(pc_out_o), .pc_plus_o(pc_plus_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o), .ras_ovf_o(ras_ovf_o)
  );

  // Narrow copy driven by the same controls, used for 8-bit wrap-around
  pc_unit #(.ADDR_W(8), .RESET_VEC(8'h0), .INSTR_BYTES(4), .RAS_DEPTH(RAS_DEPTH)) dut8 (
    .clk_i(clk_i), .rst_i(rst_i), .pc_write(pc_write),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i[7:0]),
    .jump_i(jump_i), .call_i(call_i), .jump_pc_i(jump_pc_i[7:0]), .link_pc_i(link_pc_i[7:0]),
    .ret_i(ret_i), .ret_pc_i(ret_pc_i[7:0]),
    .pc_out_o(pc8_out), .pc_plus_o(pc8_plus),
    .ras_empty_o(e8), .ras_full_o(f8), .ras_ovf_o(o8)
  );

  typedef struct {
    logic        rst, pw, rd, jp, cl, rt;
    logic [31:0] rd_pc, j_pc, l_pc, r_pc;
    logic [31:0] e_pc;
    logic        e_em, e_fu, e_ov;
  } vec_t;

  vec_t tbl[$];

  // Reference model: PC value plus RAS as a bounded queue (newest at back)
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;

  function automatic vec_t mk(logic rst, logic pw, logic rd, logic jp, logic cl, logic rt,
                              logic [31:0] rd_pc, logic [31:0] j_pc, logic [31:0] l_pc,
                              logic [31:0] r_pc, logic [31:0] e_pc,
                              logic e_em, logic e_fu, logic e_ov);
    vec_t v;
    v.rst = rst; v.pw = pw; v.rd = rd; v.jp = jp; v.cl = cl; v.rt = rt;
    v.rd_pc = rd_pc; v.j_pc = j_pc; v.l_pc = l_pc; v.r_pc = r_pc;
    v.e_pc = e_pc; v.e_em = e_em; v.e_fu = e_fu; v.e_ov = e_ov;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst_i = v.rst; pc_write = v.pw; redirect_i = v.rd;
    jump_i = v.jp; call_i = v.cl; ret_i = v.rt;
    redirect_pc_i = v.rd_pc; jump_pc_i = v.j_pc; link_pc_i = v.l_pc; ret_pc_i = v.r_pc;
  endtask

  task automatic model_step();
    logic [31:0] nxt;
    if (!rst_i) begin
      m_pc = 32'h0;
      m_ras.delete();
      m_ovf = 1'b0;
    end else if (redirect_i) begin
      m_pc = redirect_pc_i;
    end else if (pc_write) begin
      if (ret_i) begin
        if (m_ras.size() > 0) nxt = m_ras.pop_back();
        else nxt = ret_pc_i;
      end else if (jump_i || call_i) begin
        nxt = jump_pc_i;
      end else begin
        nxt = m_pc + 32'd4;
      end
      if (call_i) begin
        m_ras.push_back(link_pc_i);
        if (m_ras.size() > RAS_DEPTH) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
      end
      m_pc = nxt;
    end
  endtask

  // Advance the model with the currently driven inputs, then cross the edge
  task automatic cycle();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] mp;
    mp = m_pc + 32'd4;
    check({tag, " pc"}, pc_out_o, m_pc);
    check({tag, " pc_plus"}, pc_plus_o, mp);
    check({tag, " empty"}, 32'(ras_empty_o), 32'(m_ras.size() == 0));
    check({tag, " full"}, 32'(ras_full_o), 32'(m_ras.size() == RAS_DEPTH));
    check({tag, " ovf"}, 32'(ras_ovf_o), 32'(m_ovf));
    check({tag, " pc8"}, 32'(pc8_out), 32'(m_pc[7:0]));
    check({tag, " pc8_plus"}, 32'(pc8_plus), 32'(mp[7:0]));
    check({tag, " ovf8"}, 32'(o8), 32'(m_ovf));
  endtask

  initial begin
    vec_t v;
    apply(mk(0,0,0,0,0,0, 0,0,0,0, 0,1,0,0));
    m_pc = 32'h0; m_ovf = 1'b0;

    // reset, sequential, stall, redirect-over-stall
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0, 32'h0, 1,0,0));
    tbl.push_back(mk(0,1,0,0,0,0, 0,0,0,0, 32'h0, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'h4, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'h8, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'hC, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'h10, 1,0,0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1,0,0,0,0,0, 0,0,0,0, 32'h10, 1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0, 32'h80,0,0,0, 32'h80, 1,0,0));
    // call / return
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h200,32'h14,0, 32'h200, 0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'h204, 0,0,0));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hDEAD0, 32'h14, 1,0,0));
    // overflow: five calls (first is jump+call), four returns, fallback return
    tbl.push_back(mk(1,1,0,1,1,0, 0,32'h100,32'h4,0, 32'h100, 0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h100,32'h8,0, 32'h100, 0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h100,32'hC,0, 32'h100, 0,0,0));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h100,32'h10,0, 32'h100, 0,1,0));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h100,32'h14,0, 32'h100, 0,1,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'h14, 0,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'h10, 0,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'hC, 0,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'h8, 1,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'h40, 32'h40, 1,0,1));
    // call+ret replaces top; redirect+call leaves RAS alone; call+ret on empty
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h300,32'h30,0, 32'h300, 0,0,1));
    tbl.push_back(mk(1,1,0,0,1,1, 0,32'h900,32'h50,32'hBAD0, 32'h30, 0,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'h50, 1,0,1));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h400,32'h60,0, 32'h400, 0,0,1));
    tbl.push_back(mk(1,1,1,0,1,0, 32'h500,32'h600,32'h70,0, 32'h500, 0,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'h60, 1,0,1));
    tbl.push_back(mk(1,1,0,0,1,1, 0,32'h700,32'h90,32'h44, 32'h44, 0,0,1));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'hBAD0, 32'h90, 1,0,1));
    // fill RAS, then reset with a call pending
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h800,32'hA0,0, 32'h800, 0,0,1));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h800,32'hA4,0, 32'h800, 0,0,1));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h800,32'hA8,0, 32'h800, 0,0,1));
    tbl.push_back(mk(1,1,0,0,1,0, 0,32'h800,32'hAC,0, 32'h800, 0,1,1));
    tbl.push_back(mk(0,1,0,0,1,0, 0,32'h800,32'hB0,0, 32'h0, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'h4, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,1, 0,0,0,32'h123C, 32'h123C, 1,0,0));
    // 32-bit wrap
    tbl.push_back(mk(1,1,1,0,0,0, 32'hFFFFFFFC,0,0,0, 32'hFFFFFFFC, 1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 32'h0, 1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply(v);
      cycle();
      check($sformatf("vec%0d pc", i), pc_out_o, v.e_pc);
      check($sformatf("vec%0d pc_plus", i), pc_plus_o, v.e_pc + 32'd4);
      check($sformatf("vec%0d empty", i), 32'(ras_empty_o), 32'(v.e_em));
      check($sformatf("vec%0d full", i), 32'(ras_full_o), 32'(v.e_fu));
      check($sformatf("vec%0d ovf", i), 32'(ras_ovf_o), 32'(v.e_ov));
    end

    // 8-bit wrap on the narrow instance
    apply(mk(1,1,1,0,0,0, 32'h1FC,0,0,0, 0,0,0,0));
    cycle();
    check("wrap8 load", 32'(pc8_out), 32'h0FC);
    check("wrap8 plus", 32'(pc8_plus), 32'h000);
    apply(mk(1,1,0,0,0,0, 0,0,0,0, 0,0,0,0));
    cycle();
    check("wrap8 seq", 32'(pc8_out), 32'h000);
    check("wrap8 no flag", 32'(o8), 32'h0);

    // randomized stimulus against the queue model
    for (int n = 0; n < 3000; n++) begin
      rst_i      = ($urandom_range(0, 199) != 0);
      pc_write   = ($urandom_range(0, 7) != 0);
      redirect_i = ($urandom_range(0, 9) == 0);
      ret_i      = ($urandom_range(0, 3) == 0);
      call_i     = ($urandom_range(0, 3) == 0);
      jump_i     = ($urandom_range(0, 7) == 0);
      redirect_pc_i = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFF8 : ($urandom() & 32'hFFFFFFFC);
      jump_pc_i  = $urandom() & 32'hFFFFFFFC;
      link_pc_i  = $urandom() & 32'hFFFFFFFC;
      ret_pc_i   = $urandom() & 32'hFFFFFFFC;
      cycle();
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
